// File: rtl/rr_arbiter8.sv
// Eight-way arbiter with hold timeout and a 7-segment owner display.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (bit 7 highest).
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout,
  output logic [6:0] HEX0
);

  // state | meaning
  // IDLE  | no owner; a new grant may be issued when en=1
  // BUSY  | owner is gnt_idx; held until release or hold timeout
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [6:0]       HEX_BLANK  = 7'b1111111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;
  logic [6:0]       hex_q, hex_d;
  logic [2:0]       win;
`ifndef ARB_FIXED_PRIO_EN
  logic [2:0]       ptr_q, ptr_d;
`endif

  function automatic logic [6:0] seg7(input logic [2:0] d);
    case (d)
      3'd0:    seg7 = 7'b1000000;
      3'd1:    seg7 = 7'b1111001;
      3'd2:    seg7 = 7'b0100100;
      3'd3:    seg7 = 7'b0110000;
      3'd4:    seg7 = 7'b0011001;
      3'd5:    seg7 = 7'b0010010;
      3'd6:    seg7 = 7'b0000010;
      default: seg7 = 7'b1111000;
    endcase
  endfunction

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) win = 3'(i);
    end
  end
`else
  // Descending scan so the last hit is the nearest set bit at or after ptr.
  always_comb begin
    win = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr_q + 3'(i)]) win = ptr_q + 3'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (en && (req != 8'd0)) begin
          state_d = BUSY;
          idx_d   = win;
          vld_d   = 1'b1;
          gnt_d   = 8'b1 << win;
          cnt_d   = CNT_W'(1);
        end
      end
      BUSY: begin
        if (!req[idx_q] || ((MAX_HOLD != 0) && (cnt_q == HOLD_LIMIT))) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          gnt_d   = 8'd0;
          cnt_d   = '0;
          to_d    = req[idx_q];
`ifndef ARB_FIXED_PRIO_EN
          ptr_d   = idx_q + 3'd1;
`endif
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    hex_d = vld_d ? seg7(idx_d) : HEX_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      hex_q   <= HEX_BLANK;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      hex_q   <= hex_d;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign timeout = to_q;
  assign HEX0    = hex_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8 (MAX_HOLD=4): stimulus queues expected outputs, monitor compares.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'd0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;
  logic [6:0] HEX0;

  typedef struct {
    logic       vld;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout),
    .HEX0    (HEX0)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [2:0] d);
    case (d)
      3'd0:    seg_ref = 7'b1000000;
      3'd1:    seg_ref = 7'b1111001;
      3'd2:    seg_ref = 7'b0100100;
      3'd3:    seg_ref = 7'b0110000;
      3'd4:    seg_ref = 7'b0011001;
      3'd5:    seg_ref = 7'b0010010;
      3'd6:    seg_ref = 7'b0000010;
      default: seg_ref = 7'b1111000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Inputs applied at negedge; expected values describe outputs after the next posedge.
  task automatic step(input logic r, input logic e, input logic [7:0] rq,
                      input logic v, input logic [2:0] i, input logic t);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    req = rq;
    x.vld = v;
    x.idx = i;
    x.to  = t;
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("gnt_vld", 8'(gnt_vld), 8'(x.vld));
        chk("gnt_idx", 8'(gnt_idx), 8'(x.idx));
        chk("gnt",     gnt, x.vld ? (8'b1 << x.idx) : 8'd0);
        chk("timeout", 8'(timeout), 8'(x.to));
        chk("hex0",    8'(HEX0), 8'(x.vld ? seg_ref(x.idx) : 7'b1111111));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin : stimulus
    // single request after reset
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h08, 1, 3, 0);
    step(0, 1, 8'h00, 0, 3, 0);
    step(1, 0, 8'h00, 0, 0, 0);

`ifdef ARB_FIXED_PRIO_EN
    repeat (2) begin
      repeat (4) step(0, 1, 8'h81, 1, 7, 0);
      step(0, 1, 8'h81, 0, 7, 1);
    end
    step(0, 1, 8'h81, 1, 7, 0);
    step(0, 1, 8'h00, 0, 7, 0);
`else
    // full rotation 0..7 then back to 0
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 8'hFF, 1, 3'(k), 0);
      step(0, 1, 8'hFF, 1, 3'(k), 0);
      step(0, 1, 8'hFF & ~(8'b1 << k), 0, 3'(k), 0);
    end
    step(0, 1, 8'hFF, 1, 0, 0);
    step(0, 1, 8'hFE, 0, 0, 0);
    // wrap-around from ptr=7
    step(0, 1, 8'h40, 1, 6, 0);
    step(0, 1, 8'h00, 0, 6, 0);
    step(0, 1, 8'h05, 1, 0, 0);
    step(0, 1, 8'h04, 0, 0, 0);
    step(0, 1, 8'h04, 1, 2, 0);
    step(0, 1, 8'h00, 0, 2, 0);
    // hold timeout alternates owners 0 and 1
    repeat (4) step(0, 1, 8'h03, 1, 0, 0);
    step(0, 1, 8'h03, 0, 0, 1);
    repeat (4) step(0, 1, 8'h03, 1, 1, 0);
    step(0, 1, 8'h03, 0, 1, 1);
    step(0, 1, 8'h03, 1, 0, 0);
    step(0, 1, 8'h00, 0, 0, 0);
`endif

    // enable gating and reset while busy
    step(1, 0, 8'h10, 0, 0, 0);
    repeat (5) step(0, 0, 8'h10, 0, 0, 0);
    step(0, 1, 8'h10, 1, 4, 0);
    step(0, 1, 8'h10, 1, 4, 0);
    step(1, 1, 8'h10, 0, 0, 0);

`ifndef ARB_FIXED_PRIO_EN
    step(0, 1, 8'hFF, 1, 0, 0);
    step(0, 0, 8'hFF, 1, 0, 0);
    step(0, 0, 8'hFE, 0, 0, 0);
    step(0, 0, 8'hFF, 0, 0, 0);
    step(0, 0, 8'hFF, 0, 0, 0);
    repeat (4) step(0, 1, 8'hFF, 1, 1, 0);
    // release exactly at the hold limit: no timeout pulse
    step(0, 1, 8'hFD, 0, 1, 0);
    step(0, 1, 8'hFD, 1, 2, 0);
    step(0, 1, 8'h00, 0, 2, 0);
`endif

    @(posedge clk);
    #2;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
